wb_gpio_slave: RTL and testbench
================================

# wb_gpio_slave

Wishbone classic-cycle responder exposing a general-purpose I/O port to the CPU's data bus. It is the slave end of the data-side Wishbone master interface (`dwishbone_*`). It provides direction/output/input registers, rising-edge interrupt capture on inputs, and a level interrupt output suitable for the core's `int_i`. Address decode of the block's base is done externally; this block decodes only the register offset.

## Interface
Parameters:
- `GPIO_W`, default 32. Number of GPIO pins, legal range 1..32. Register bits above `GPIO_W` read as 0 and ignore writes.

Ports:
- `clk` in 1 — single clock; all logic is on its rising edge.
- `rst` in 1 — asynchronous, active-low reset; 0 = reset asserted.
- `wb_addr_i` in 32 — byte address; only [4:2] are decoded, all other bits are ignored.
- `wb_data_i` in 32 — write data.
- `wb_data_o` out 32 — read data; valid only while `wb_ack_o`=1, otherwise 0.
- `wb_we_i` in 1 — 1 = write, 0 = read.
- `wb_sel_i` in 4 — byte lanes; `sel[n]` covers bits [8n+7:8n].
- `wb_stb_i` in 1 — strobe.
- `wb_cyc_i` in 1 — cycle valid.
- `wb_ack_o` out 1 — single-cycle acknowledge.
- `gpio_i` in GPIO_W — asynchronous pin inputs.
- `gpio_o` out GPIO_W — output values.
- `gpio_oe_o` out GPIO_W — output enables; 1 = drive.
- `int_o` out 1 — registered level interrupt.

## Operation
- Register map (offset = `wb_addr_i[4:2]`×4):
  - 0x00 `IN`, RO — synchronized `gpio_i`.
  - 0x04 `OUT`, RW — drives `gpio_o`.
  - 0x08 `OE`, RW — drives `gpio_oe_o`.
  - 0x0C `IEN`, RW — interrupt enable per pin.
  - 0x10 `ISTAT`, W1C — sticky rising-edge flags.
  - 0x14–0x1C — reserved; read 0, writes ignored, still acknowledged.
- Bus state machine:
  - IDLE: if `stb&cyc`, perform the access at this edge and go to ACK. Otherwise stay in IDLE.
  - ACK: `wb_ack_o`=1 for exactly one cycle; unconditionally return to IDLE. `stb` is not sampled in ACK, so a held strobe is never double-acknowledged.
- Writes (RW registers): `reg[8n+7:8n] <= wb_data_i[...]` for each `sel[n]`=1. Lanes with `sel[n]`=0 are unchanged.
- ISTAT write: clear bit i where `wb_data_i[i]`=1 and its byte lane is selected.
- Read: `wb_data_o` is captured at the IDLE→ACK edge, zero-extended from GPIO_W, and held only during ACK. `wb_sel_i` does not mask read data.
- Input path:
  - 2-flop synchronizer on `gpio_i` → `IN`.
  - A third flop holds the previous `IN`. Edge i is detected when `IN[i]`=1 and prev[i]=0.
  - Edge detection sets `ISTAT[i]` regardless of `IEN` and `OE`.
  - If a set and a W1C clear of the same bit occur on the same edge, set wins.
- `int_o <= |(ISTAT & IEN)`, registered.
- Reset values: all registers, synchronizer flops, `wb_ack_o`, `wb_data_o`, `gpio_o`, `gpio_oe_o` and `int_o` are 0; state = IDLE. Reset mid-access drops `wb_ack_o` immediately and aborts the access.

## Timing
- Access latency: `stb&cyc` sampled high at edge N → `wb_ack_o` high N→N+1.
- Write data is visible on `gpio_o`/`gpio_oe_o` from edge N.
- Back-to-back accesses: `stb` re-sampled at N+2 at the earliest. Throughput is one access per 2 cycles.
- Input latency:
  - `gpio_i` rises before edge M → `IN` updates at M+1.
  - `ISTAT` set at M+2.
  - `int_o` high at M+3, provided `IEN` is set.
- Clearing `ISTAT` at edge N → `int_o` low at N+1, unless a new edge re-sets the bit.
- `stb` without `cyc`, or `cyc` without `stb`: no access and no ack.

## Test plan
- After reset, read 0x00/0x04/0x08/0x0C/0x10 with `gpio_i`=0 → every read returns 0x00000000 with ack exactly one cycle after `stb`, and `int_o`=0.
- Write 0x04 = 0xA5A5A5A5 with `sel`=4'b0101, then read 0x04 → 0x00A500A5; `gpio_o`=0x00A500A5 from the ack cycle.
- Hold `stb`/`cyc` high for 5 cycles on a read → ack pulses on cycles 2 and 4 only, never on consecutive cycles.
- Set `IEN`=0x1; raise `gpio_i[0]` → `IN`[0]=1 after 2 edges, `ISTAT`=0x1 after 3 edges, `int_o`=1 after 4 edges. Write `ISTAT`=0x1 with `sel`=4'b0001 → `int_o`=0 next cycle.
- Raise `gpio_i[3]` timed so the edge detection coincides with an `ISTAT` write of 0x8 → `ISTAT[3]` remains 1.
- Assert `rst`=0 during an ACK cycle → `wb_ack_o`, `gpio_o` and `gpio_oe_o` go to 0 immediately. After release, `stb` is served normally.

Source files
------------

// File: rtl/wb_gpio_slave.sv
// Wishbone classic-cycle GPIO responder: OUT/OE/IEN registers, synchronized IN,
// sticky rising-edge ISTAT flags (write-1-to-clear) and a registered level interrupt.
module wb_gpio_slave #(
  parameter int GPIO_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       wb_addr_i,
  input  logic [31:0]       wb_data_i,
  output logic [31:0]       wb_data_o,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe_o,
  output logic              int_o
);

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } state_e;

  typedef enum logic [2:0] {
    OFF_IN    = 3'd0,
    OFF_OUT   = 3'd1,
    OFF_OE    = 3'd2,
    OFF_IEN   = 3'd3,
    OFF_ISTAT = 3'd4
  } offset_e;

  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [GPIO_W-1:0] out_q, out_d;
  logic [GPIO_W-1:0] oe_q, oe_d;
  logic [GPIO_W-1:0] ien_q, ien_d;
  logic [GPIO_W-1:0] istat_q, istat_d;
  logic              int_q, int_d;
  logic [GPIO_W-1:0] sync1_q, in_q, prev_q;

  logic              access;
  logic              wr_en;
  logic [2:0]        offset;
  logic [31:0]       be_mask;
  logic [GPIO_W-1:0] lane_mask;
  logic [GPIO_W-1:0] wdata;
  logic [GPIO_W-1:0] edge_det;
  logic [31:0]       rd_word;

  // Block base decode and byte offset are handled upstream.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wb_addr_i[31:5], wb_addr_i[1:0]};

  // ACK is not a sampling state, so a held strobe gets one ack per two cycles.
  assign access   = (state_q == ST_IDLE) && wb_stb_i && wb_cyc_i;
  assign wr_en    = access && wb_we_i;
  assign offset   = wb_addr_i[4:2];
  assign wdata    = wb_data_i[GPIO_W-1:0];
  assign edge_det = in_q & ~prev_q;

  // NOTE: every variable written in always_comb gets a default first; a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    be_mask = '0;
    for (int n = 0; n < 4; n++) begin
      be_mask[8*n +: 8] = {8{wb_sel_i[n]}};
    end
    lane_mask = be_mask[GPIO_W-1:0];
  end

  // Read mux is zero-extended; the byte lanes do not mask read data.
  always_comb begin
    rd_word = '0;
    case (offset)
      OFF_IN:    rd_word[GPIO_W-1:0] = in_q;
      OFF_OUT:   rd_word[GPIO_W-1:0] = out_q;
      OFF_OE:    rd_word[GPIO_W-1:0] = oe_q;
      OFF_IEN:   rd_word[GPIO_W-1:0] = ien_q;
      OFF_ISTAT: rd_word[GPIO_W-1:0] = istat_q;
      default:   rd_word = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          if (!wb_we_i) begin
            rdata_d = rd_word;
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    ien_d = ien_q;
    if (wr_en) begin
      case (offset)
        OFF_OUT: out_d = (out_q & ~lane_mask) | (wdata & lane_mask);
        OFF_OE:  oe_d  = (oe_q  & ~lane_mask) | (wdata & lane_mask);
        OFF_IEN: ien_d = (ien_q & ~lane_mask) | (wdata & lane_mask);
        default: ;
      endcase
    end
  end

  // A fresh edge on the same cycle as its W1C clear keeps the flag set.
  always_comb begin
    istat_d = istat_q | edge_det;
    if (wr_en && (offset == OFF_ISTAT)) begin
      istat_d = (istat_q & ~(wdata & lane_mask)) | edge_det;
    end
    int_d = |(istat_q & ien_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      out_q   <= '0;
      oe_q    <= '0;
      ien_q   <= '0;
      istat_q <= '0;
      int_q   <= 1'b0;
      sync1_q <= '0;
      in_q    <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      ien_q   <= ien_d;
      istat_q <= istat_d;
      int_q   <= int_d;
      sync1_q <= gpio_i;
      in_q    <= sync1_q;
      prev_q  <= in_q;
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_data_o = rdata_q;
  assign gpio_o    = out_q;
  assign gpio_oe_o = oe_q;
  assign int_o     = int_q;

endmodule

// File: tb/tb_wb_gpio_slave.sv
// Directed bench for wb_gpio_slave: register access, held strobe, edge capture,
// set-wins W1C collision and reset during an ack.
module tb_wb_gpio_slave;

  localparam int GPIO_W = 32;

  logic              clk;
  logic              rst;
  logic [31:0]       wb_addr_i;
  logic [31:0]       wb_data_i;
  logic [31:0]       wb_data_o;
  logic              wb_we_i;
  logic [3:0]        wb_sel_i;
  logic              wb_stb_i;
  logic              wb_cyc_i;
  logic              wb_ack_o;
  logic [GPIO_W-1:0] gpio_i;
  logic [GPIO_W-1:0] gpio_o;
  logic [GPIO_W-1:0] gpio_oe_o;
  logic              int_o;

  int n_total = 0;
  int n_bad   = 0;

  wb_gpio_slave #(.GPIO_W(GPIO_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_addr_i (wb_addr_i),
    .wb_data_i (wb_data_i),
    .wb_data_o (wb_data_o),
    .wb_we_i   (wb_we_i),
    .wb_sel_i  (wb_sel_i),
    .wb_stb_i  (wb_stb_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_ack_o  (wb_ack_o),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe_o (gpio_oe_o),
    .int_o     (int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One classic cycle: drive after a falling edge, sample 1ns after the access edge.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] sel, output logic ack, output logic [31:0] rdata);
    @(negedge clk);
    wb_we_i   = we;
    wb_addr_i = addr;
    wb_data_i = data;
    wb_sel_i  = sel;
    wb_stb_i  = 1'b1;
    wb_cyc_i  = 1'b1;
    @(posedge clk);
    #1;
    ack   = wb_ack_o;
    rdata = wb_data_o;
    @(negedge clk);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [3:0] sel,
                    input logic [31:0] exp);
    logic        ack;
    logic [31:0] rdata;
    bus(1'b0, addr, 32'h0, sel, ack, rdata);
    check({tag, "_ack"}, {31'd0, ack}, 32'd1);
    check(tag, rdata, exp);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] sel);
    logic        ack;
    logic [31:0] rdata;
    bus(1'b1, addr, data, sel, ack, rdata);
    check({tag, "_ack"}, {31'd0, ack}, 32'd1);
  endtask

  initial begin
    logic [4:0] ack_hist;
    logic [3:0] int_hist;

    rst       = 1'b0;
    wb_addr_i = '0;
    wb_data_i = '0;
    wb_we_i   = 1'b0;
    wb_sel_i  = 4'h0;
    wb_stb_i  = 1'b0;
    wb_cyc_i  = 1'b0;
    gpio_i    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_int", {31'd0, int_o}, 32'd0);
    check("rst_gpio_o", gpio_o, 32'h0);
    check("rst_gpio_oe", gpio_oe_o, 32'h0);

    // Every implemented register reads zero out of reset.
    rd("rst_in",    32'h00, 4'hF, 32'h0);
    rd("rst_out",   32'h04, 4'hF, 32'h0);
    rd("rst_oe",    32'h08, 4'hF, 32'h0);
    rd("rst_ien",   32'h0C, 4'hF, 32'h0);
    rd("rst_istat", 32'h10, 4'hF, 32'h0);
    check("rst_int2", {31'd0, int_o}, 32'd0);

    // Byte-lane writes; gpio_o updates on the access edge itself.
    wr("out_wr1", 32'h04, 32'hA5A5_A5A5, 4'b0101);
    check("out_gpio1", gpio_o, 32'h00A5_00A5);
    rd("out_rd1", 32'h04, 4'hF, 32'h00A5_00A5);
    @(posedge clk);
    #1;
    check("ack_drop", {31'd0, wb_ack_o}, 32'd0);
    check("data_drop", wb_data_o, 32'h0);
    wr("out_wr2", 32'h04, 32'h5A5A_5A5A, 4'b1010);
    check("out_gpio2", gpio_o, 32'h5AA5_5AA5);
    rd("out_rd_nosel", 32'h04, 4'h0, 32'h5AA5_5AA5);
    rd("out_rd_hiaddr", 32'h8000_0107, 4'hF, 32'h5AA5_5AA5);
    wr("oe_wr", 32'h08, 32'hFFFF_0000, 4'hF);
    check("oe_gpio", gpio_oe_o, 32'hFFFF_0000);
    rd("oe_rd", 32'h08, 4'hF, 32'hFFFF_0000);
    wr("rsv_wr", 32'h14, 32'hFFFF_FFFF, 4'hF);
    rd("rsv_rd", 32'h14, 4'hF, 32'h0);
    rd("rsv_rd1c", 32'h1C, 4'hF, 32'h0);

    // Strobe without cycle, and cycle without strobe: no access.
    @(negedge clk);
    wb_we_i = 1'b1; wb_addr_i = 32'h04; wb_data_i = 32'h0; wb_sel_i = 4'hF;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b0;
    @(posedge clk);
    #1;
    check("stb_only_ack", {31'd0, wb_ack_o}, 32'd0);
    @(negedge clk);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b1;
    @(posedge clk);
    #1;
    check("cyc_only_ack", {31'd0, wb_ack_o}, 32'd0);
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    check("no_access_out", gpio_o, 32'h5AA5_5AA5);

    // Held strobe: acks on alternate edges only.
    @(negedge clk);
    wb_addr_i = 32'h04; wb_sel_i = 4'hF; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      ack_hist[k] = wb_ack_o;
      if (k == 3) begin
        @(negedge clk);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      end
    end
    check("held_stb_acks", {27'd0, ack_hist}, 32'b00101);

    // Rising edge on pin 0 with IEN set: int_o three edges after the capture edge.
    wr("ien_wr", 32'h0C, 32'h0000_0001, 4'b0001);
    gpio_i[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      int_hist[k] = int_o;
    end
    check("int_latency", {28'd0, int_hist}, 32'b1000);
    rd("in_rd", 32'h00, 4'hF, 32'h0000_0001);
    rd("istat_rd", 32'h10, 4'hF, 32'h0000_0001);
    wr("istat_clr", 32'h10, 32'h0000_0001, 4'b0001);
    @(posedge clk);
    #1;
    check("int_cleared", {31'd0, int_o}, 32'd0);
    rd("istat_rd0", 32'h10, 4'hF, 32'h0);

    // Edge on a pin without IEN still latches ISTAT but raises no interrupt.
    @(negedge clk);
    gpio_i[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_ien_int", {31'd0, int_o}, 32'd0);
    rd("no_ien_istat", 32'h10, 4'hF, 32'h0000_0002);
    wr("istat_clr2", 32'h10, 32'h0000_0002, 4'b0001);
    rd("istat_rd0b", 32'h10, 4'hF, 32'h0);

    // Edge detection on pin 3 lands on the same edge as its W1C clear.
    @(negedge clk);
    gpio_i[3] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wr("collide_wr", 32'h10, 32'h0000_0008, 4'b0001);
    rd("collide_rd", 32'h10, 4'hF, 32'h0000_0008);
    wr("clr_unsel", 32'h10, 32'h0000_0008, 4'b0010);
    rd("clr_unsel_rd", 32'h10, 4'hF, 32'h0000_0008);
    wr("clr_sel", 32'h10, 32'h0000_0008, 4'b0001);
    rd("clr_sel_rd", 32'h10, 4'hF, 32'h0);

    // Reset asserted while ack is high.
    wr("pre_rst_out", 32'h04, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    wb_we_i = 1'b0; wb_addr_i = 32'h08; wb_sel_i = 4'hF; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_ack", {31'd0, wb_ack_o}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("mid_rst_gpio_o", gpio_o, 32'h0);
    check("mid_rst_gpio_oe", gpio_oe_o, 32'h0);
    check("mid_rst_data", wb_data_o, 32'h0);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    gpio_i = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rd("post_rst_oe", 32'h08, 4'hF, 32'h0);
    rd("post_rst_out", 32'h04, 4'hF, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
